// File: rtl/serial_subtractor_pkg.sv
// Purpose : shared state encoding and default width for the bit-serial subtractor.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package sub_pkg;

    localparam int DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// Purpose : 1-bit full subtractor, a - b - bor_in.
// Latency : combinational.
// Backpressure: none.
// Ports: a_in/b_in operand bits, bor_in borrow in; diff_out difference bit, bor_out borrow out.
module full_subtractor (
    input  logic a_in,
    input  logic b_in,
    input  logic bor_in,
    output logic diff_out,
    output logic bor_out
);

    assign diff_out = a_in ^ b_in ^ bor_in;
    // Borrow out when b exceeds a outright, or when they tie and a borrow is pending.
    assign bor_out  = (~a_in & b_in) | (~(a_in ^ b_in) & bor_in);

endmodule

// File: rtl/serial_subtractor.sv
// Purpose : bit-serial WIDTH-bit unsigned subtractor, diff = a - b, LSB first.
// Latency : WIDTH+1 cycles start-to-done; one operation per WIDTH+2 cycles.
// Backpressure: start_in is only sampled in IDLE; requests while busy_out=1 are dropped.
// Ports: clk/rst_n (async active-low); start_in, a_in, b_in request side;
//        busy_out, done_out (1-cycle pulse), diff_out, borrow_out result side.
module serial_subtractor
    import sub_pkg::*;
#(
    parameter  int WIDTH = DEF_WIDTH,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy_out,
    output logic             done_out,
    output logic [WIDTH-1:0] diff_out,
    output logic             borrow_out
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    // Only WIDTH-1 result bits are stored; the final bit goes straight to diff_out.
    logic [WIDTH-2:0] res_sr;
    logic [CNT_W-1:0] count;
    logic             br;
    logic             d_bit;
    logic             br_next;
    logic [WIDTH-1:0] res_next;

    full_subtractor u_fs (
        .a_in     (a_sr[0]),
        .b_in     (b_sr[0]),
        .bor_in   (br),
        .diff_out (d_bit),
        .bor_out  (br_next)
    );

    // New bit enters at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
    assign res_next = {d_bit, res_sr};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            a_sr       <= '0;
            b_sr       <= '0;
            res_sr     <= '0;
            count      <= '0;
            br         <= 1'b0;
            busy_out   <= 1'b0;
            done_out   <= 1'b0;
            diff_out   <= '0;
            borrow_out <= 1'b0;
        end else begin
            done_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_in) begin
                        a_sr     <= a_in;
                        b_sr     <= b_in;
                        br       <= 1'b0;
                        count    <= '0;
                        busy_out <= 1'b1;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    res_sr <= res_next[WIDTH-1:1];
                    br     <= br_next;
                    count  <= count + 1'b1;
                    if (count == LAST) begin
                        // Results update only here and hold across later starts.
                        diff_out   <= res_next;
                        borrow_out <= br_next;
                        done_out   <= 1'b1;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    busy_out <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    busy_out <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        start8;
    logic [7:0]  a8, b8, diff8;
    logic        busy8, done8, borrow8;

    logic        start16;
    logic [15:0] a16, b16, diff16;
    logic        busy16, done16, borrow16;

    logic        fa, fb, fc, fd, fbo;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) u_dut8 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_in   (start8),
        .a_in       (a8),
        .b_in       (b8),
        .busy_out   (busy8),
        .done_out   (done8),
        .diff_out   (diff8),
        .borrow_out (borrow8)
    );

    serial_subtractor #(.WIDTH(16)) u_dut16 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_in   (start16),
        .a_in       (a16),
        .b_in       (b16),
        .busy_out   (busy16),
        .done_out   (done16),
        .diff_out   (diff16),
        .borrow_out (borrow16)
    );

    full_subtractor u_fs (
        .a_in     (fa),
        .b_in     (fb),
        .bor_in   (fc),
        .diff_out (fd),
        .bor_out  (fbo)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One 8-bit operation: checks busy length and done position, returns the result.
    task automatic run8(input logic [7:0] a, input logic [7:0] b,
                        output logic [7:0] d, output logic br);
        int busy_cnt;
        int done_at;
        busy_cnt = 0;
        done_at  = 0;
        d        = 'x;
        br       = 1'bx;
        @(negedge clk);
        start8 = 1'b1; a8 = a; b8 = b;
        @(negedge clk);
        start8 = 1'b0; a8 = ~a; b8 = ~b;   // operands may wander after the start edge
        for (int i = 1; i <= 30; i++) begin
            if (!busy8) break;
            busy_cnt++;
            if (done8 && done_at == 0) begin
                done_at = i;
                d  = diff8;
                br = borrow8;
            end
            @(negedge clk);
        end
        chk("done_cycle", done_at, 9);
        chk("busy_len", busy_cnt, 9);
    endtask

    task automatic run16(input logic [15:0] a, input logic [15:0] b,
                         output logic [15:0] d, output logic br);
        d  = 'x;
        br = 1'bx;
        @(negedge clk);
        start16 = 1'b1; a16 = a; b16 = b;
        @(negedge clk);
        start16 = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            if (done16) begin
                d  = diff16;
                br = borrow16;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
    endtask

    initial begin
        logic [7:0]  d;
        logic        br;
        logic [15:0] d16;
        logic        br16;
        logic [7:0]  fs_d_tab;
        logic [7:0]  fs_b_tab;
        logic [8:0]  ref9;
        logic [16:0] ref17;
        logic [7:0]  ra, rb;
        logic [15:0] ra16, rb16;
        int          seen_done;
        int          n;

        rst_n = 1'b0; start8 = 1'b0; a8 = '0; b8 = '0;
        start16 = 1'b0; a16 = '0; b16 = '0;
        fa = 1'b0; fb = 1'b0; fc = 1'b0;

        // Full subtractor truth table, index {a,b,bor_in}.
        fs_d_tab = 8'b1001_0110;
        fs_b_tab = 8'b1000_1110;
        for (int i = 0; i < 8; i++) begin
            {fa, fb, fc} = 3'(i);
            #1;
            chk("fs_diff", {31'd0, fd}, {31'd0, fs_d_tab[i]});
            chk("fs_bor", {31'd0, fbo}, {31'd0, fs_b_tab[i]});
        end

        #12;
        chk("rst_busy", {31'd0, busy8}, 0);
        chk("rst_done", {31'd0, done8}, 0);
        chk("rst_diff", {24'd0, diff8}, 0);
        chk("rst_borrow", {31'd0, borrow8}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run8(8'd200, 8'd55, d, br);
        chk("200-55", {24'd0, d}, 145);
        chk("200-55_br", {31'd0, br}, 0);
        run8(8'd5, 8'd10, d, br);
        chk("5-10", {24'd0, d}, 8'hFB);
        chk("5-10_br", {31'd0, br}, 1);
        run8(8'd0, 8'd1, d, br);
        chk("0-1", {24'd0, d}, 8'hFF);
        chk("0-1_br", {31'd0, br}, 1);
        run8(8'd255, 8'd255, d, br);
        chk("255-255", {24'd0, d}, 0);
        chk("255-255_br", {31'd0, br}, 0);
        run8(8'd0, 8'd0, d, br);
        chk("0-0", {24'd0, d}, 0);
        chk("0-0_br", {31'd0, br}, 0);
        run8(8'h80, 8'h01, d, br);
        chk("80-01", {24'd0, d}, 8'h7F);
        chk("80-01_br", {31'd0, br}, 0);

        // Start requests during SHIFT and DONE must be dropped.
        @(negedge clk);
        start8 = 1'b1; a8 = 8'd200; b8 = 8'd55;
        @(negedge clk);
        start8 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        start8 = 1'b1; a8 = 8'd9; b8 = 8'd3;
        @(negedge clk);
        start8 = 1'b0;
        seen_done = 0;
        for (int i = 0; i < 30 && seen_done == 0; i++) begin
            @(negedge clk);
            if (done8) seen_done = 1;
        end
        chk("ign_done_seen", seen_done, 1);
        start8 = 1'b1;                     // asserted during DONE, then held
        chk("ign_diff", {24'd0, diff8}, 145);
        chk("ign_br", {31'd0, borrow8}, 0);
        @(negedge clk);
        chk("held_idle_busy", {31'd0, busy8}, 0);
        @(negedge clk);
        chk("held_accept_busy", {31'd0, busy8}, 1);
        start8 = 1'b0;
        chk("held_diff_kept", {24'd0, diff8}, 145);
        seen_done = 0;
        n = 0;
        for (int i = 0; i < 30 && seen_done == 0; i++) begin
            @(negedge clk);
            n++;
            if (done8) seen_done = 1;
        end
        chk("held_done_seen", seen_done, 1);
        chk("held_done_cycle", n, 8);
        chk("held_diff", {24'd0, diff8}, 6);
        chk("held_br", {31'd0, borrow8}, 0);
        @(negedge clk);

        // Reset four cycles into an operation.
        @(negedge clk);
        start8 = 1'b1; a8 = 8'd5; b8 = 8'd10;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", {31'd0, busy8}, 0);
        chk("mid_rst_diff", {24'd0, diff8}, 0);
        chk("mid_rst_br", {31'd0, borrow8}, 0);
        chk("mid_rst_done", {31'd0, done8}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done8) seen_done = 1;
        end
        chk("no_done_after_rst", seen_done, 0);
        run8(8'd5, 8'd10, d, br);
        chk("post_rst", {24'd0, d}, 8'hFB);
        chk("post_rst_br", {31'd0, br}, 1);

        // Random regression against a 9-bit reference subtraction.
        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            ref9 = {1'b0, ra} - {1'b0, rb};
            run8(ra, rb, d, br);
            chk("rnd8_diff", {24'd0, d}, {24'd0, ref9[7:0]});
            chk("rnd8_br", {31'd0, br}, {31'd0, ref9[8]});
        end

        run16(16'd0, 16'd1, d16, br16);
        chk("w16_0-1", {16'd0, d16}, 16'hFFFF);
        chk("w16_0-1_br", {31'd0, br16}, 1);
        run16(16'h8000, 16'h0001, d16, br16);
        chk("w16_8000-1", {16'd0, d16}, 16'h7FFF);
        chk("w16_8000-1_br", {31'd0, br16}, 0);
        for (int i = 0; i < 200; i++) begin
            ra16 = 16'($urandom);
            rb16 = 16'($urandom);
            ref17 = {1'b0, ra16} - {1'b0, rb16};
            run16(ra16, rb16, d16, br16);
            chk("rnd16_diff", {16'd0, d16}, {16'd0, ref17[15:0]});
            chk("rnd16_br", {31'd0, br16}, {31'd0, ref17[16]});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
